// File: rtl/nexys4_pkg.sv
// Shared definitions for the nexys4 Rojobot interface: controller state
// encoding, Rojobot register snapshot payload and PicoBlaze port addresses.
package nexys4_pkg;

  localparam int unsigned BOT_REG_W = 8;
  localparam int unsigned PORT_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // One coherent set of Rojobot registers.
  typedef struct packed {
    logic [BOT_REG_W-1:0] locx;
    logic [BOT_REG_W-1:0] locy;
    logic [BOT_REG_W-1:0] botinfo;
    logic [BOT_REG_W-1:0] sensors;
    logic [BOT_REG_W-1:0] lmdist;
    logic [BOT_REG_W-1:0] rmdist;
  } bot_regs_t;

  // Read-mux port addresses for the snapshot registers.
  localparam logic [PORT_W-1:0] PA_LOCX    = 8'h0A;
  localparam logic [PORT_W-1:0] PA_LOCY    = 8'h0B;
  localparam logic [PORT_W-1:0] PA_BOTINFO = 8'h0C;
  localparam logic [PORT_W-1:0] PA_SENSORS = 8'h0D;
  localparam logic [PORT_W-1:0] PA_LMDIST  = 8'h0E;
  localparam logic [PORT_W-1:0] PA_RMDIST  = 8'h0F;

  localparam logic [PORT_W-1:0] PA_LOCX_ALT    = 8'h1A;
  localparam logic [PORT_W-1:0] PA_LOCY_ALT    = 8'h1B;
  localparam logic [PORT_W-1:0] PA_BOTINFO_ALT = 8'h1C;
  localparam logic [PORT_W-1:0] PA_SENSORS_ALT = 8'h1D;
  localparam logic [PORT_W-1:0] PA_LMDIST_ALT  = 8'h1E;
  localparam logic [PORT_W-1:0] PA_RMDIST_ALT  = 8'h1F;

  // Motor-control write port; its write ends the ISR (isr_done decode).
  localparam logic [PORT_W-1:0] PA_MOTCTL_IN = 8'h09;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear priority over increment.
// Ports: sysclk, sysreset (sync, active-high), inc, clr, cnt[W-1:0].
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         sysclk,
  input  logic         sysreset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge sysclk) begin
    if (sysreset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bot_update_ctl.sv
// Rojobot update sequencer: snapshots the six Rojobot registers on each
// update pulse, raises a PicoBlaze interrupt, holds the snapshot until the
// ISR completes, coalesces updates arriving meanwhile and counts overruns.
// Ports:
//   sysclk, sysreset            clock, synchronous active-high reset
//   upd_sysregs                 Rojobot update pulse
//   int_enable                  interrupt mode (0 = snapshot tracks live)
//   live_*                      live Rojobot registers
//   interrupt_ack, isr_done     PicoBlaze handshake pulses
//   clr_status                  clears overrun_cnt and timeout_flag
//   snap_*                      frozen snapshot for the read mux
//   interrupt, overrun_cnt, timeout_flag, busy   status (all registered)
module bot_update_ctl
  import nexys4_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned TMR_W       = 11
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic                 upd_sysregs,
  input  logic                 int_enable,
  input  logic [BOT_REG_W-1:0] live_locx,
  input  logic [BOT_REG_W-1:0] live_locy,
  input  logic [BOT_REG_W-1:0] live_botinfo,
  input  logic [BOT_REG_W-1:0] live_sensors,
  input  logic [BOT_REG_W-1:0] live_lmdist,
  input  logic [BOT_REG_W-1:0] live_rmdist,
  input  logic                 interrupt_ack,
  input  logic                 isr_done,
  input  logic                 clr_status,
  output logic [BOT_REG_W-1:0] snap_locx,
  output logic [BOT_REG_W-1:0] snap_locy,
  output logic [BOT_REG_W-1:0] snap_botinfo,
  output logic [BOT_REG_W-1:0] snap_sensors,
  output logic [BOT_REG_W-1:0] snap_lmdist,
  output logic [BOT_REG_W-1:0] snap_rmdist,
  output logic                 interrupt,
  output logic [7:0]           overrun_cnt,
  output logic                 timeout_flag,
  output logic                 busy
);

  localparam int unsigned  CNT_W    = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t           state, state_nxt;
  bot_regs_t        live, snap;
  logic [TMR_W-1:0] timer;
  logic             pend, pend_nxt;
  logic             load_snap, timeout_hit, ovr_inc;

  assign live = '{locx: live_locx, locy: live_locy, botinfo: live_botinfo,
                  sensors: live_sensors, lmdist: live_lmdist, rmdist: live_rmdist};

  assign snap_locx    = snap.locx;
  assign snap_locy    = snap.locy;
  assign snap_botinfo = snap.botinfo;
  assign snap_sensors = snap.sensors;
  assign snap_lmdist  = snap.lmdist;
  assign snap_rmdist  = snap.rmdist;

  // State register.
  always_ff @(posedge sysclk) begin
    if (sysreset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, pending-update tracking and datapath strobes.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    load_snap   = 1'b0;
    timeout_hit = 1'b0;
    ovr_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (upd_sysregs) begin
          load_snap = 1'b1;
          if (int_enable) state_nxt = PEND;
        end
      end
      PEND: begin
        ovr_inc = upd_sysregs && pend;
        if (upd_sysregs) pend_nxt = 1'b1;
        if (interrupt_ack) begin
          state_nxt = SERVICE;
        end else if (timer == TMR_LAST) begin
          // Withdrawn interrupt abandons the sequence, pending update too.
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
          pend_nxt    = 1'b0;
        end
      end
      SERVICE: begin
        ovr_inc = upd_sysregs && pend;
        if (upd_sysregs) pend_nxt = 1'b1;
        if (isr_done) begin
          if (pend || upd_sysregs) begin
            load_snap = 1'b1;
            pend_nxt  = 1'b0;
            state_nxt = PEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, timer, pending flag and registered status outputs.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      snap         <= '0;
      timer        <= '0;
      pend         <= 1'b0;
      interrupt    <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (load_snap) snap <= live;
      // Timer only runs in PEND; it is zero on every entry to PEND.
      if (state == PEND) timer <= timer + TMR_W'(1);
      else               timer <= '0;
      pend      <= pend_nxt;
      interrupt <= (state_nxt == PEND);
      busy      <= (state_nxt != IDLE);
      if (clr_status)       timeout_flag <= 1'b0;
      else if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_overrun (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .inc      (ovr_inc),
    .clr      (clr_status),
    .cnt      (overrun_cnt)
  );

endmodule

// File: tb/tb_bot_update_ctl.sv
module tb_bot_update_ctl;

  localparam int unsigned ACK_TIMEOUT = 8;
  localparam int unsigned TMR_W       = 4;

  localparam int SEL_INT  = 0;
  localparam int SEL_BUSY = 1;
  localparam int SEL_LOCX = 2;
  localparam int SEL_SENS = 3;
  localparam int SEL_OVR  = 4;
  localparam int SEL_TOF  = 5;
  localparam int SEL_SNAP = 6;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       sysreset, upd_sysregs, int_enable, interrupt_ack, isr_done, clr_status;
  logic [7:0] live_locx, live_locy, live_botinfo, live_sensors, live_lmdist, live_rmdist;
  logic [7:0] snap_locx, snap_locy, snap_botinfo, snap_sensors, snap_lmdist, snap_rmdist;
  logic       interrupt, timeout_flag, busy;
  logic [7:0] overrun_cnt;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 sysclk = ~sysclk;

  bot_update_ctl #(.ACK_TIMEOUT(ACK_TIMEOUT), .TMR_W(TMR_W)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .upd_sysregs(upd_sysregs),
    .int_enable(int_enable),
    .live_locx(live_locx), .live_locy(live_locy), .live_botinfo(live_botinfo),
    .live_sensors(live_sensors), .live_lmdist(live_lmdist), .live_rmdist(live_rmdist),
    .interrupt_ack(interrupt_ack), .isr_done(isr_done), .clr_status(clr_status),
    .snap_locx(snap_locx), .snap_locy(snap_locy), .snap_botinfo(snap_botinfo),
    .snap_sensors(snap_sensors), .snap_lmdist(snap_lmdist), .snap_rmdist(snap_rmdist),
    .interrupt(interrupt), .overrun_cnt(overrun_cnt), .timeout_flag(timeout_flag),
    .busy(busy)
  );

  function automatic int observe(int sel);
    case (sel)
      SEL_INT:  return int'(interrupt);
      SEL_BUSY: return int'(busy);
      SEL_LOCX: return int'(snap_locx);
      SEL_SENS: return int'(snap_sensors);
      SEL_OVR:  return int'(overrun_cnt);
      SEL_TOF:  return int'(timeout_flag);
      default:  return int'(snap_locx | snap_locy | snap_botinfo |
                            snap_sensors | snap_lmdist | snap_rmdist);
    endcase
  endfunction

  // Monitor: drains expectations at the falling edge after each stimulus step.
  always @(negedge sysclk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act;
      e   = sb.pop_front();
      act = observe(e.sel);
      total++;
      if (act != e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(string name, int sel, int exp);
    sb.push_back('{name: name, sel: sel, exp: exp});
  endtask

  // One clock edge; single-cycle pulses drop right after it.
  task automatic tick();
    @(posedge sysclk);
    #1;
    upd_sysregs   = 1'b0;
    interrupt_ack = 1'b0;
    isr_done      = 1'b0;
    clr_status    = 1'b0;
  endtask

  task automatic pulse_upd();   upd_sysregs = 1'b1;   tick(); endtask
  task automatic pulse_ack();   interrupt_ack = 1'b1; tick(); endtask
  task automatic pulse_done();  isr_done = 1'b1;      tick(); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sysreset = 1'b1; upd_sysregs = 1'b0; int_enable = 1'b0;
    interrupt_ack = 1'b0; isr_done = 1'b0; clr_status = 1'b0;
    live_locx = 8'h00; live_locy = 8'h11; live_botinfo = 8'h22;
    live_sensors = 8'h33; live_lmdist = 8'h44; live_rmdist = 8'h66;
    tick(); tick();
    sysreset = 1'b0;
    expect_val("rst_int", SEL_INT, 0);
    expect_val("rst_busy", SEL_BUSY, 0);
    expect_val("rst_snap", SEL_SNAP, 0);
    expect_val("rst_ovr", SEL_OVR, 0);
    expect_val("rst_tof", SEL_TOF, 0);
    tick();

    // 1: basic update / ack / done handshake
    int_enable = 1'b1; live_locx = 8'h42;
    pulse_upd();
    expect_val("t1_int", SEL_INT, 1);
    expect_val("t1_locx", SEL_LOCX, 8'h42);
    expect_val("t1_busy", SEL_BUSY, 1);
    pulse_ack();
    expect_val("t1_ack_int", SEL_INT, 0);
    expect_val("t1_ack_busy", SEL_BUSY, 1);
    pulse_done();
    expect_val("t1_done_busy", SEL_BUSY, 0);
    expect_val("t1_done_int", SEL_INT, 0);

    // 2: coalesced updates during SERVICE
    pulse_upd();
    pulse_ack();
    live_locx = 8'h55;
    pulse_upd(); pulse_upd(); pulse_upd();
    expect_val("t2_frozen", SEL_LOCX, 8'h42);
    expect_val("t2_ovr", SEL_OVR, 2);
    expect_val("t2_svc_int", SEL_INT, 0);
    pulse_done();
    expect_val("t2_reload", SEL_LOCX, 8'h55);
    expect_val("t2_reint", SEL_INT, 1);
    pulse_ack();
    pulse_done();
    expect_val("t2_idle", SEL_BUSY, 0);

    // 3: ack timeout, interrupt high for exactly ACK_TIMEOUT cycles
    clr_status = 1'b1; tick();
    expect_val("t3_clr_ovr", SEL_OVR, 0);
    pulse_upd();
    expect_val("t3_int_c0", SEL_INT, 1);
    for (int i = 1; i < int'(ACK_TIMEOUT); i++) begin
      tick();
      expect_val($sformatf("t3_int_c%0d", i), SEL_INT, 1);
    end
    tick();
    expect_val("t3_expired_int", SEL_INT, 0);
    expect_val("t3_tof", SEL_TOF, 1);
    expect_val("t3_idle", SEL_BUSY, 0);
    clr_status = 1'b1; tick();
    expect_val("t3_tof_clr", SEL_TOF, 0);

    // 4: upd coincident with isr_done, then ack on the expiry cycle
    pulse_upd();
    pulse_ack();
    live_locx = 8'h77;
    upd_sysregs = 1'b1; isr_done = 1'b1; tick();
    expect_val("t4_fresh", SEL_LOCX, 8'h77);
    expect_val("t4_int", SEL_INT, 1);
    expect_val("t4_ovr", SEL_OVR, 0);
    for (int i = 1; i < int'(ACK_TIMEOUT); i++) tick();
    expect_val("t4_pre_expiry_int", SEL_INT, 1);
    pulse_ack();
    expect_val("t4_ack_int", SEL_INT, 0);
    expect_val("t4_ack_busy", SEL_BUSY, 1);
    expect_val("t4_no_tof", SEL_TOF, 0);
    pulse_done();
    expect_val("t4_idle", SEL_BUSY, 0);

    // 5: overrun saturation and clear-over-increment priority
    pulse_upd();
    pulse_ack();
    for (int i = 0; i < 300; i++) pulse_upd();
    expect_val("t5_sat", SEL_OVR, 8'hFF);
    clr_status = 1'b1; upd_sysregs = 1'b1; tick();
    expect_val("t5_clr_win", SEL_OVR, 0);
    pulse_done();
    expect_val("t5_reload_int", SEL_INT, 1);
    pulse_ack();
    pulse_done();
    expect_val("t5_idle", SEL_BUSY, 0);

    // 6: transparent mode, then reset in PEND
    int_enable = 1'b0; live_sensors = 8'hA5;
    pulse_upd();
    expect_val("t6_sens", SEL_SENS, 8'hA5);
    expect_val("t6_no_int", SEL_INT, 0);
    expect_val("t6_no_busy", SEL_BUSY, 0);
    int_enable = 1'b1;
    pulse_upd();
    expect_val("t6_pend_int", SEL_INT, 1);
    sysreset = 1'b1; tick();
    sysreset = 1'b0;
    expect_val("t6_rst_int", SEL_INT, 0);
    expect_val("t6_rst_snap", SEL_SNAP, 0);
    expect_val("t6_rst_busy", SEL_BUSY, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge sysclk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    @(posedge sysclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bot_update_ctl.md
Name: bot_update_ctl

Overview:
- Sequences Rojobot register updates into the PicoBlaze interrupt mechanism.
- On each Rojobot update pulse it freezes a coherent snapshot of the six Rojobot registers (LocX, LocY, BotInfo, Sensors, LMDist, RMDist) and raises a closed-loop interrupt.
- It holds the snapshot stable until the ISR signals completion, coalesces updates that arrive meanwhile and counts overruns.
- Sits between the Rojobot and the nexys4 register interface; the snapshot outputs feed the read mux ports 0x0A–0x0F / 0x1A–0x1F.

Parameters:
ACK_TIMEOUT, 1024, sysclk cycles allowed in PEND before the interrupt is withdrawn (must be ≥2)
TMR_W, 11, width of timeout counter (≥ clog2(ACK_TIMEOUT+1))

Ports:
sysclk  in  1  system clock; single clock domain
sysreset  in  1  synchronous reset, active-high
upd_sysregs  in  1  one-cycle pulse from Rojobot: live registers were just updated
int_enable  in  1  1 = updates raise interrupts; 0 = snapshot tracks live inputs, no interrupts
live_locx, live_locy, live_botinfo, live_sensors, live_lmdist, live_rmdist  in  8 each  live Rojobot registers
interrupt_ack  in  1  PicoBlaze interrupt acknowledge pulse
isr_done  in  1  one-cycle pulse, decoded externally from the ISR's final port write
clr_status  in  1  clears overrun_cnt and timeout_flag
snap_locx, snap_locy, snap_botinfo, snap_sensors, snap_lmdist, snap_rmdist  out  8 each  frozen snapshot
interrupt  out  1  interrupt request to PicoBlaze (registered)
overrun_cnt  out  8  saturating count of coalesced (lost) updates
timeout_flag  out  1  sticky: an interrupt expired without ack
busy  out  1  state != IDLE

Behaviour:
- Reset (sysreset=1 at a clock edge):
  - state=IDLE, all snap_* = 0x00, interrupt=0, overrun_cnt=0, timeout_flag=0, pend=0, timer=0.
  - Reset mid-operation aborts any interrupt immediately; a pending update is discarded.
- IDLE:
  - int_enable=0: each upd_sysregs loads snap_* from live_* at that edge; no interrupt.
  - int_enable=1 and upd_sysregs at edge N: snap_* loaded at N, interrupt=1 visible after N, timer=0, state→PEND.
  - interrupt_ack and isr_done are ignored.
- PEND:
  - interrupt held at 1; timer increments each cycle.
  - interrupt_ack: interrupt=0 next cycle, state→SERVICE.
  - timer reaches ACK_TIMEOUT-1 without ack: interrupt=0, timeout_flag=1, state→IDLE.
  - ack in the same cycle as expiry: ack wins, no flag.
- SERVICE:
  - snap_* frozen; interrupt=0.
  - isr_done with pend=1: snap_* reload from live_*, pend=0, interrupt=1 next cycle, timer=0, state→PEND.
  - isr_done with pend=0: state→IDLE.
- Coalescing (any upd_sysregs in PEND or SERVICE):
  - Sets pend=1 and does not touch snap_*.
  - If pend was already 1 and is not consumed in that same cycle, overrun_cnt increments, saturating at 255.
  - upd_sysregs coincident with isr_done in SERVICE counts as pending: the reload takes fresh values, and there is no overrun unless pend was already 1.
  - upd_sysregs coincident with ack in PEND: ack takes effect and pend is set.
- int_enable deasserted outside IDLE: the current sequence completes normally; pend is still honoured.
- clr_status coincident with an increment or timeout: clear wins (result 0 / 0).
- interrupt is always a flop output, never combinational.

Decomposition:
- Shared package nexys4_pkg:
  - state enum {IDLE, PEND, SERVICE} (2-bit, binary).
  - Port-address constants PA_LOCX..PA_RMDIST (0x0A–0x0F) and their _ALT variants (0x1A–0x1F).
  - PA_MOTCTL_IN (0x09), used by the isr_done decoder.
- One natural sub-module: sat_counter (parameterised width, inc/clr, clr priority), used for overrun_cnt.

Test Plan:
1. Reset, int_enable=1, live_locx=0x42, pulse upd_sysregs → next cycle interrupt=1, snap_locx=0x42; ack → interrupt=0, busy=1; isr_done → IDLE, busy=0.
2. In SERVICE, change live_locx=0x55 and pulse upd_sysregs three times → snap_locx stays 0x42, overrun_cnt=2; isr_done → snap_locx=0x55, interrupt=1 next cycle.
3. ACK_TIMEOUT=8, update with no ack → interrupt high exactly 8 cycles, then 0, timeout_flag=1, state IDLE; clr_status → flag 0.
4. Simultaneous upd_sysregs+isr_done in SERVICE with pend=0 → PEND with fresh snapshot, overrun_cnt unchanged; ack coincident with timer expiry → SERVICE, timeout_flag=0.
5. Force 300 coalesced updates → overrun_cnt saturates at 0xFF; clr_status coincident with another update → 0x00.
6. int_enable=0, upd_sysregs with live_sensors=0xA5 → snap_sensors=0xA5, interrupt stays 0; sysreset asserted in PEND → interrupt=0, all snap_*=0 next cycle.
